// File: rtl/sra_iter.sv
// Iterative 32-bit right shifter: five fixed-latency stages of 16/8/4/2/1-bit
// conditional shifts, with logical or arithmetic fill and a valid/ready handshake.
module sra_iter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic        in_arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         stage;
  logic signed [31:0] work;
  logic [4:0]         shamt;
  logic               fill;

  // Shift right by amt, filling vacated MSBs with f.
  function automatic logic signed [31:0] shift_fill(input logic signed [31:0] v,
                                                    input logic [4:0] amt,
                                                    input logic f);
    logic [63:0] ext;
    ext = {{32{f}}, v} >> amt;
    return $signed(ext[31:0]);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      stage <= 3'd0;
      work  <= '0;
      shamt <= '0;
      fill  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= $signed(in_data);
            shamt <= in_shamt;
            fill  <= in_arith & in_data[31];
            stage <= 3'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Stage k consumes shamt bit 4-k, i.e. the 16-bit step first.
          if (shamt[3'd4 - stage])
            work <= shift_fill(work, 5'd16 >> stage, fill);
          if (stage == 3'd4)
            state <= DONE;
          else
            stage <= stage + 3'd1;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;

endmodule

// File: tb/tb_sra_iter.sv
// Randomized self-checking bench for sra_iter against a plain-arithmetic shift model.
module tb_sra_iter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  sra_iter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_arith (in_arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] d, input int s, input bit a);
    logic signed [31:0] sd;
    sd = $signed(d);
    if (a) return 32'(sd >>> s);
    return d >> s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One full transaction; hold = cycles to stall in DONE with a competing in_valid.
  task automatic run_req(input logic [31:0] d, input logic [4:0] s, input bit a,
                         input int hold, input string tag);
    int n;
    logic [31:0] exp;
    exp = model(d, int'(s), a);
    @(negedge clock);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_arith = a;
    @(posedge clock); #1;
    in_valid = 1'b0; in_data = $urandom; in_shamt = 5'($urandom); in_arith = 1'($urandom);
    check({tag, ":busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (!out_valid) check({tag, ":busy_shift"}, 32'(busy), 32'd1);
    end
    check({tag, ":latency"}, 32'(n), 32'd5);
    check({tag, ":data"}, out_data, exp);
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, ":hold_data"}, out_data, exp);
        check({tag, ":hold_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, ":release_busy"}, 32'(busy), 32'd0);
    check({tag, ":release_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    int tcyc[$];
    logic [31:0] tdat[$];
    int acc_cyc;
    logic [31:0] d1, d2;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    // Request presented during reset must not be accepted.
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    repeat (3) @(posedge clock);
    #1;
    check("rst_no_accept", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(negedge clock); reset_n = 1'b1;

    run_req(32'h80000000, 5'd31, 1'b1, 0, "msb31_arith");
    run_req(32'h80000000, 5'd31, 1'b0, 0, "msb31_logic");
    run_req(32'hF0F0F0F0, 5'd4,  1'b0, 0, "f0_4_logic");
    run_req(32'hF0F0F0F0, 5'd4,  1'b1, 0, "f0_4_arith");
    run_req(32'h7FFFFFFF, 5'd30, 1'b1, 0, "pos30_arith");
    run_req(32'h12345678, 5'd0,  1'b0, 0, "zero_logic");
    run_req(32'h92345678, 5'd0,  1'b1, 0, "zero_arith");
    run_req(32'hA5A5A5A5, 5'd13, 1'b1, 10, "stall");

    // Reset pulse during stage 2 discards the transaction.
    @(negedge clock);
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_shamt = 5'd7; in_arith = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b0; #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock); reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (out_valid || busy) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);

    // Back-to-back with in_valid and out_ready held high.
    d1 = $urandom; d2 = $urandom;
    @(negedge clock);
    in_valid = 1'b1; in_data = d1; in_shamt = 5'd9; in_arith = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    acc_cyc = cyc;
    in_data = d2; in_shamt = 5'd21; in_arith = 1'b0;
    for (int i = 0; i < 30 && tcyc.size() < 2; i++) begin
      @(posedge clock); #1;
      if (out_valid) begin
        tcyc.push_back(cyc); tdat.push_back(out_data);
        if (tcyc.size() == 2) in_valid = 1'b0;
      end
    end
    check("b2b_count", 32'(tcyc.size()), 32'd2);
    if (tcyc.size() == 2) begin
      check("b2b_first_lat", 32'(tcyc[0] - acc_cyc), 32'd5);
      check("b2b_spacing", 32'(tcyc[1] - tcyc[0]), 32'd7);
      check("b2b_data0", tdat[0], model(d1, 9, 1'b1));
      check("b2b_data1", tdat[1], model(d2, 21, 1'b0));
    end
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("b2b_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 24; i++)
      run_req($urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
